seq_pipe_sum_accum: RTL and testbench
=====================================

// Module: seq_pipe_sum_accum
//
// PURPOSE
// - Downstream consumer of the 8-bit two-stage add3 pipeline result stream.
// - Accumulates NSAMPLES accepted 8-bit sums into one wide total.
// - Presents the total on a val/rdy output interface and holds it under backpressure.
// - Supports back-to-back windows with no bubble when the sink is ready.
//
// PARAMETERS
// - NSAMPLES   4   samples per window; legal range 1..255
// - OUT_NBITS  16  accumulator/output width; must be >= 8
//
// PORTS
// - clk      input   1          clock; all state updates on posedge
// - reset    input   1          synchronous, active-high reset
// - in_val   input   1          upstream sum valid
// - in_rdy   output  1          block can accept a sample this cycle
// - in       input   8          upstream 8-bit sum (unsigned)
// - out_val  output  1          window total valid
// - out_rdy  input   1          downstream accepts total this cycle
// - out      output  OUT_NBITS  window total
//
// BEHAVIOUR
// - Transfers: in-xfer = in_val & in_rdy; out-xfer = out_val & out_rdy.
// - Registers:
//   - state {ACCUM, DONE}
//   - acc[OUT_NBITS]
//   - cnt[8]
//   - out[OUT_NBITS]
// - Reset: state=ACCUM, acc=0, cnt=0, out=0, out_val=0.
//   - in_rdy=1 in the first cycle after reset deasserts.
//   - Reset mid-window or mid-hold discards all partial and pending data.
// - Output decodes (no combinational in->out path):
//   - out_val = (state==DONE)
//   - in_rdy  = (state==ACCUM) | (state==DONE & out_rdy)
// - ACCUM, in-xfer with cnt < NSAMPLES-1:
//   - acc <= acc + zext(in); cnt <= cnt+1; stay in ACCUM.
// - ACCUM, in-xfer with cnt == NSAMPLES-1:
//   - out <= acc + zext(in); acc <= 0; cnt <= 0; go to DONE.
// - ACCUM, no in-xfer: hold all state.
// - DONE, out_rdy=0: hold out and out_val. No sample accepted (in_rdy=0).
// - DONE, out_rdy=1, no in-xfer: go to ACCUM. out keeps its last value.
// - DONE, out_rdy=1, in-xfer (simultaneous drain and fill):
//   - The sample starts the next window: acc <= zext(in), cnt <= 1, go to ACCUM.
//   - If NSAMPLES==1: out <= zext(in) and stay in DONE.
// - Latency: out_val rises the cycle after the NSAMPLES-th in-xfer.
// - Throughput: one sample per cycle sustained while out_rdy=1 whenever out_val=1.
// - Arithmetic: unsigned, modulo 2^OUT_NBITS. Wrap is silent; no overflow flag.
// - in is don't-care when in_val=0.
// - out is stable while out_val=1 and out_rdy=0.
//
// TESTING
// - Reset, then in_val=0 for 5 cycles -> out_val=0, out=0, in_rdy=1 every cycle.
// - N=4, in_val=1 with 10,20,30,40, out_rdy=1 -> out_val=1 for one cycle, out=100,
//   next cycle after 4th sample.
// - Same stimulus, out_rdy=0 for 3 cycles after out_val -> out holds 100, in_rdy=0
//   for 3 cycles; on out_rdy=1 the 5th sample (7) is accepted the same cycle; the
//   next window total includes 7.
// - N=4, OUT_NBITS=8, samples 255,255,255,255 -> out=252 (1020 mod 256).
// - Reset asserted after 2 of 4 samples (5,6) then samples 1,2,3,4 -> out=10, not 21.
// - N=1, 8 back-to-back samples 1..8 with out_rdy=1 -> out=1..8 on consecutive
//   cycles, out_val held high, in_rdy never drops.

Source files
------------

// File: rtl/seq_pipe_sum_accum.sv
// Window accumulator for the 8-bit add3 pipeline sum stream: sums NSAMPLES
// accepted samples and presents the total on a val/rdy port, holding it under backpressure.
module seq_pipe_sum_accum #(
   parameter int unsigned NSAMPLES  = 4,
   parameter int unsigned OUT_NBITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_val,
   output logic                 in_rdy,
   input  logic [7:0]           in,
   output logic                 out_val,
   input  logic                 out_rdy,
   output logic [OUT_NBITS-1:0] out
);

   localparam logic [7:0] LAST_CNT = 8'(NSAMPLES - 1);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t               state;
   logic [OUT_NBITS-1:0] acc;
   logic [7:0]           cnt;
   logic                 in_xfer;
   logic [OUT_NBITS-1:0] sample;
   logic [OUT_NBITS-1:0] sum;

   // Decodes depend only on state and out_rdy, so there is no in->out path.
   assign out_val = (state == DONE);
   assign in_rdy  = (state == ACCUM) | ((state == DONE) & out_rdy);
   assign in_xfer = in_val & in_rdy;
   assign sample  = OUT_NBITS'(in);
   assign sum     = acc + sample;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ACCUM;
         acc   <= '0;
         cnt   <= '0;
         out   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_xfer) begin
                  if (cnt == LAST_CNT) begin
                     out   <= sum;
                     acc   <= '0;
                     cnt   <= '0;
                     state <= DONE;
                  end else begin
                     acc <= sum;
                     cnt <= cnt + 8'd1;
                  end
               end
            end
            DONE: begin
               // Draining while a new sample arrives starts the next window with no bubble.
               if (out_rdy) begin
                  if (in_xfer) begin
                     if (NSAMPLES == 1) begin
                        out <= sample;
                     end else begin
                        acc   <= sample;
                        cnt   <= 8'd1;
                        state <= ACCUM;
                     end
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pipe_sum_accum.sv
// Bench for seq_pipe_sum_accum: three configurations share one stimulus stream,
// each tracked by a protocol model feeding a per-instance scoreboard queue.
module tb_seq_pipe_sum_accum;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_val;
   logic [7:0]  in;
   logic        out_rdy;

   logic        in_rdy_a, out_val_a;
   logic [15:0] out_a;
   logic        in_rdy_b, out_val_b;
   logic [7:0]  out_b;
   logic        in_rdy_c, out_val_c;
   logic [15:0] out_c;

   int n_checks = 0;
   int n_errors = 0;

   // Model state, index 0: N=4/16b, 1: N=4/8b, 2: N=1/16b
   int unsigned nsamp [3];
   int unsigned mask  [3];
   bit          m_done[3];
   int unsigned m_acc [3];
   int unsigned m_cnt [3];
   int unsigned m_last[3];
   int unsigned q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   seq_pipe_sum_accum #(.NSAMPLES(4), .OUT_NBITS(16)) dut_a (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_a), .in(in),
      .out_val(out_val_a), .out_rdy(out_rdy), .out(out_a));

   seq_pipe_sum_accum #(.NSAMPLES(4), .OUT_NBITS(8)) dut_b (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_b), .in(in),
      .out_val(out_val_b), .out_rdy(out_rdy), .out(out_b));

   seq_pipe_sum_accum #(.NSAMPLES(1), .OUT_NBITS(16)) dut_c (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_c), .in(in),
      .out_val(out_val_c), .out_rdy(out_rdy), .out(out_c));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int q_size(input int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic int unsigned q_front(input int d);
      case (d)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic q_pop(input int d);
      case (d)
         0:       void'(q0.pop_front());
         1:       void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endtask

   task automatic q_push(input int d, input int unsigned v);
      case (d)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_done[d] = 1'b0;
         m_acc[d]  = 0;
         m_cnt[d]  = 0;
         m_last[d] = 0;
      end
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   // One clock: check outputs at negedge, advance the model at posedge.
   task automatic step();
      logic [31:0] obs_o[3];
      logic        obs_v[3];
      logic        obs_r[3];
      bit          m_rdy;
      bit          xfer[3];
      int unsigned exp_v;
      @(negedge clk);
      obs_o = '{32'(out_a), 32'(out_b), 32'(out_c)};
      obs_v = '{out_val_a, out_val_b, out_val_c};
      obs_r = '{in_rdy_a, in_rdy_b, in_rdy_c};
      for (int d = 0; d < 3; d++) begin
         m_rdy = !m_done[d] || out_rdy;
         check($sformatf("d%0d_in_rdy", d), 32'(obs_r[d]), 32'(m_rdy));
         check($sformatf("d%0d_out_val", d), 32'(obs_v[d]), 32'(m_done[d]));
         if (m_done[d]) begin
            if (q_size(d) == 0) begin
               check($sformatf("d%0d_sb_empty", d), 32'(q_size(d)), 32'd1);
            end else begin
               exp_v = q_front(d);
               check($sformatf("d%0d_out", d), obs_o[d], exp_v);
               if (out_rdy) begin
                  q_pop(d);
                  m_last[d] = exp_v;
               end
            end
         end else begin
            check($sformatf("d%0d_out_idle", d), obs_o[d], m_last[d]);
         end
         xfer[d] = in_val && m_rdy;
      end
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (!m_done[d]) begin
               if (xfer[d]) begin
                  if (m_cnt[d] == nsamp[d] - 1) begin
                     q_push(d, (m_acc[d] + 32'(in)) & mask[d]);
                     m_acc[d]  = 0;
                     m_cnt[d]  = 0;
                     m_done[d] = 1'b1;
                  end else begin
                     m_acc[d] = (m_acc[d] + 32'(in)) & mask[d];
                     m_cnt[d] = m_cnt[d] + 1;
                  end
               end
            end else if (out_rdy) begin
               if (xfer[d]) begin
                  if (nsamp[d] == 1) begin
                     q_push(d, 32'(in));
                  end else begin
                     m_acc[d]  = 32'(in);
                     m_cnt[d]  = 1;
                     m_done[d] = 1'b0;
                  end
               end else begin
                  m_done[d] = 1'b0;
               end
            end
         end
      end
      #1;
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input bit rdy);
      in_val  = v;
      in      = d;
      out_rdy = rdy;
      step();
   endtask

   initial begin
      nsamp = '{4, 4, 1};
      mask  = '{32'hFFFF, 32'hFF, 32'hFFFF};
      reset   = 1'b1;
      in_val  = 1'b0;
      in      = 8'd0;
      out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset = 1'b0;

      // Idle after reset
      repeat (5) drive(1'b0, 8'd0, 1'b1);
      check("rst_out", 32'(out_a), 32'd0);
      check("rst_in_rdy", 32'(in_rdy_a), 32'd1);

      // Basic window 10+20+30+40
      drive(1'b1, 8'd10, 1'b1);
      drive(1'b1, 8'd20, 1'b1);
      drive(1'b1, 8'd30, 1'b1);
      check("win_not_yet", 32'(out_val_a), 32'd0);
      drive(1'b1, 8'd40, 1'b1);
      check("win_val", 32'(out_val_a), 32'd1);
      check("win_out", 32'(out_a), 32'd100);
      check("n1_out40", 32'(out_c), 32'd40);
      drive(1'b0, 8'd0, 1'b1);
      check("win_val_drop", 32'(out_val_a), 32'd0);
      check("win_out_keep", 32'(out_a), 32'd100);

      // Backpressure hold, then simultaneous drain and fill with 7
      drive(1'b1, 8'd10, 1'b1);
      drive(1'b1, 8'd20, 1'b1);
      drive(1'b1, 8'd30, 1'b1);
      drive(1'b1, 8'd40, 1'b1);
      repeat (3) drive(1'b1, 8'd7, 1'b0);
      check("bp_out_hold", 32'(out_a), 32'd100);
      check("bp_val_hold", 32'(out_val_a), 32'd1);
      check("bp_in_rdy", 32'(in_rdy_a), 32'd0);
      drive(1'b1, 8'd7, 1'b1);
      check("fill_val", 32'(out_val_a), 32'd0);
      drive(1'b1, 8'd1, 1'b1);
      drive(1'b1, 8'd2, 1'b1);
      drive(1'b1, 8'd3, 1'b1);
      check("fill_out", 32'(out_a), 32'd13);

      // Wrap in the 8-bit instance
      repeat (4) drive(1'b1, 8'd255, 1'b1);
      check("wrap8_out", 32'(out_b), 32'd252);
      check("wrap16_out", 32'(out_a), 32'd1020);
      drive(1'b0, 8'd0, 1'b1);

      // Reset mid-window discards partial sum
      drive(1'b1, 8'd5, 1'b1);
      drive(1'b1, 8'd6, 1'b1);
      reset = 1'b1;
      drive(1'b0, 8'd0, 1'b1);
      reset = 1'b0;
      check("midrst_out", 32'(out_a), 32'd0);
      drive(1'b1, 8'd1, 1'b1);
      drive(1'b1, 8'd2, 1'b1);
      drive(1'b1, 8'd3, 1'b1);
      drive(1'b1, 8'd4, 1'b1);
      check("midrst_sum", 32'(out_a), 32'd10);

      // N=1 back-to-back
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 8'(i), 1'b1);
         check($sformatf("n1_out_%0d", i), 32'(out_c), 32'(i));
         check($sformatf("n1_val_%0d", i), 32'(out_val_c), 32'd1);
         check($sformatf("n1_rdy_%0d", i), 32'(in_rdy_c), 32'd1);
      end
      check("n4_after_16", 32'(out_a), 32'd26);

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) < 2);
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 2) != 0));
      end
      reset = 1'b0;
      repeat (3) drive(1'b0, 8'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
